mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares the single-port data memory array (i_Dcache storage) between the core's
//  instruction-fetch port (IF) and load/store port (LS). Grants one access at a time,
//  drives the memory request lines and returns read data to the winner after a fixed
//  memory latency. LS has priority; a starvation counter guarantees IF forward progress.
// PARAMETERS
//  ADDR_W      32  address width, byte address, both ports and memory
//  DATA_W      32  data width; byte enables are DATA_W/8 bits
//  MEM_LAT     1   memory read latency in cycles, >=1; mem_rdata_i valid MEM_LAT cycles after mem_req_o
//  STARVE_MAX  4   consecutive IF losses after which IF wins the next grant, >=1
// PORTS
//  clk          in   1         core clock
//  rst_n        in   1         asynchronous reset, active low
//  if_req_i     in   1         IF request; held with if_addr_i until if_gnt_o
//  if_addr_i    in   ADDR_W    IF fetch address
//  if_gnt_o     out  1         IF request accepted this cycle
//  if_rvalid_o  out  1         IF read data valid (one-cycle pulse)
//  if_rdata_o   out  DATA_W    IF read data
//  ls_req_i     in   1         LS request; held with all ls_* until ls_gnt_o
//  ls_we_i      in   1         1 = store, 0 = load
//  ls_be_i      in   DATA_W/8  store byte enables
//  ls_addr_i    in   ADDR_W    LS address
//  ls_wdata_i   in   DATA_W    store data
//  ls_gnt_o     out  1         LS request accepted this cycle
//  ls_rvalid_o  out  1         LS load data valid / store complete (one-cycle pulse)
//  ls_rdata_o   out  DATA_W    LS load data
//  mem_req_o    out  1         memory access strobe
//  mem_we_o     out  1         memory write enable
//  mem_be_o     out  DATA_W/8  memory byte enables (all ones for IF)
//  mem_addr_o   out  ADDR_W    memory address
//  mem_wdata_o  out  DATA_W    memory write data
//  mem_rdata_i  in   DATA_W    memory read data
// BEHAVIOUR
//  Reset (rst_n=0, async): state IDLE, latency counter 0, owner NONE, starve counter 0;
//   all *_gnt_o, *_rvalid_o, mem_req_o, mem_we_o = 0; mem_* buses and rdata = 0.
//  States: IDLE (no access in flight), BUSY (access in flight, counter counts MEM_LAT..1).
//  Grant opportunity: state IDLE, or BUSY with counter==1 (response cycle) -> back-to-back.
//  At a grant opportunity with any req: pick winner, assert its gnt_o and mem_req_o in
//   same cycle (combinational from regs + req); mem_addr/we/be/wdata muxed from winner.
//   Next state BUSY, counter=MEM_LAT, owner=winner. No req: next state IDLE, mem_req_o=0.
//  No grant while BUSY with counter>1; requests simply wait (req held by requester).
//  Priority: LS wins unless starve counter == STARVE_MAX, then IF wins.
//  Starve counter: +1 when IF requests but LS wins; cleared when IF granted or if_req_i=0;
//   saturates at STARVE_MAX.
//  Response: in cycle counter==1, owner's rvalid_o=1 for exactly one cycle; rdata_o =
//   mem_rdata_i (combinational); non-owner rdata_o = 0. Stores also pulse ls_rvalid_o.
//  IF accesses: mem_we_o=0, mem_be_o all ones, mem_wdata_o=0.
//  Latency: grant at T -> rvalid at T+MEM_LAT. Throughput: 1 access per MEM_LAT cycles.
//  Reset mid-access: in-flight access abandoned, no rvalid after rst_n deasserts.
//  Requester deasserting req before gnt: legal, nothing issued.
// TESTING
//  1 rst_n=0 with both reqs high -> all gnt/rvalid/mem_req 0; release -> LS granted first cycle.
//  2 MEM_LAT=1, IF only addr 0x100, mem_rdata 0x00000013 -> if_gnt T, if_rvalid T+1 rdata 0x13.
//  3 MEM_LAT=1, IF+LS req at T -> ls_gnt T, if_gnt T+1, ls_rvalid T+1, if_rvalid T+2.
//  4 STARVE_MAX=4, LS and IF held high -> LS wins 4 grants, IF wins 5th, LS 6th.
//  5 LS store we=1 be=4'b0011 addr 0x2000 wdata 0xDEADBEEF -> mem_we=1,be=0011 at T; ls_rvalid T+MEM_LAT.
//  6 MEM_LAT=3, grant T -> no gnt T+1,T+2, rvalid T+3; rst_n low at T+1 -> no rvalid ever.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares the single-port data memory array between the instruction-fetch
// port (IF) and the load/store port (LS). Only one access is in flight at a
// time. Read data is returned to the port that owns the access a fixed
// MEM_LAT cycles after the grant. LS has priority. A starvation counter
// gives IF the next grant after STARVE_MAX consecutive losses.
//
// Parameters
//   ADDR_W      byte address width (ports and memory)
//   DATA_W      data width; byte enables are DATA_W/8 bits
//   MEM_LAT     memory read latency in cycles (>= 1)
//   STARVE_MAX  consecutive IF losses before IF is forced to win (>= 1)
//
// Ports
//   clk, rst_n          core clock, asynchronous active-low reset
//   if_req_i/if_addr_i  IF request and fetch address, held until if_gnt_o
//   if_gnt_o            IF request accepted this cycle
//   if_rvalid_o         IF read data valid (one-cycle pulse)
//   if_rdata_o          IF read data (zero when not valid)
//   ls_req_i            LS request, held with all ls_* until ls_gnt_o
//   ls_we_i/ls_be_i     store enable / store byte enables
//   ls_addr_i           LS address
//   ls_wdata_i          store data
//   ls_gnt_o            LS request accepted this cycle
//   ls_rvalid_o         LS load data valid / store complete (one-cycle pulse)
//   ls_rdata_o          LS load data (zero when not valid)
//   mem_req_o           memory access strobe
//   mem_we_o/mem_be_o   memory write enable / byte enables (all ones for IF)
//   mem_addr_o          memory address
//   mem_wdata_o         memory write data
//   mem_rdata_i         memory read data, valid MEM_LAT cycles after mem_req_o
// ---------------------------------------------------------------------------
module mem_port_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int MEM_LAT    = 1,
    parameter int STARVE_MAX = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,

    input  logic                  if_req_i,
    input  logic [ADDR_W-1:0]     if_addr_i,
    output logic                  if_gnt_o,
    output logic                  if_rvalid_o,
    output logic [DATA_W-1:0]     if_rdata_o,

    input  logic                  ls_req_i,
    input  logic                  ls_we_i,
    input  logic [DATA_W/8-1:0]   ls_be_i,
    input  logic [ADDR_W-1:0]     ls_addr_i,
    input  logic [DATA_W-1:0]     ls_wdata_i,
    output logic                  ls_gnt_o,
    output logic                  ls_rvalid_o,
    output logic [DATA_W-1:0]     ls_rdata_o,

    output logic                  mem_req_o,
    output logic                  mem_we_o,
    output logic [DATA_W/8-1:0]   mem_be_o,
    output logic [ADDR_W-1:0]     mem_addr_o,
    output logic [DATA_W-1:0]     mem_wdata_o,
    input  logic [DATA_W-1:0]     mem_rdata_i
);

    localparam int BE_W  = DATA_W / 8;
    localparam int CNT_W = $clog2(MEM_LAT + 1);
    localparam int ST_W  = $clog2(STARVE_MAX + 1);

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LAT);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [ST_W-1:0]  ST_MAX   = ST_W'(STARVE_MAX);
    localparam logic [ST_W-1:0]  ST_ONE   = ST_W'(1);

    // Arbiter states
    localparam logic [0:0] S_IDLE = 1'b0;  // no access in flight
    localparam logic [0:0] S_BUSY = 1'b1;  // access in flight, counter MEM_LAT..1

    // Owner of the access in flight
    localparam logic [1:0] OWN_NONE = 2'd0;
    localparam logic [1:0] OWN_IF   = 2'd1;
    localparam logic [1:0] OWN_LS   = 2'd2;

    logic [0:0]       state_q,  state_d;
    logic [CNT_W-1:0] cnt_q,    cnt_d;
    logic [1:0]       owner_q,  owner_d;
    logic [ST_W-1:0]  starve_q, starve_d;

    logic resp_cyc;
    logic grant_opp;
    logic starve_full;
    logic if_win;
    logic ls_win;
    logic if_gnt;
    logic ls_gnt;

    // -----------------------------------------------------------------------
    // Arbitration
    // -----------------------------------------------------------------------

    // The response cycle doubles as a grant opportunity so back-to-back
    // accesses reach one per MEM_LAT cycles.
    assign resp_cyc    = (state_q == S_BUSY) && (cnt_q == CNT_ONE);
    assign grant_opp   = (state_q == S_IDLE) || resp_cyc;
    assign starve_full = (starve_q == ST_MAX);

    assign if_win = grant_opp && if_req_i && (!ls_req_i || starve_full);
    assign ls_win = grant_opp && ls_req_i && !(if_req_i && starve_full);

    // Grants are combinational from registers and requests, so they would
    // otherwise be visible while reset is held; rst_n masks only the outputs
    // and never feeds the state registers.
    assign if_gnt = rst_n && if_win;
    assign ls_gnt = rst_n && ls_win;

    assign if_gnt_o  = if_gnt;
    assign ls_gnt_o  = ls_gnt;
    assign mem_req_o = if_gnt || ls_gnt;

    // -----------------------------------------------------------------------
    // Memory request mux
    // -----------------------------------------------------------------------
    always_comb begin
        mem_we_o    = 1'b0;
        mem_be_o    = '0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        if (ls_gnt) begin
            mem_we_o    = ls_we_i;
            mem_be_o    = ls_be_i;
            mem_addr_o  = ls_addr_i;
            mem_wdata_o = ls_wdata_i;
        end else if (if_gnt) begin
            mem_be_o    = {BE_W{1'b1}};
            mem_addr_o  = if_addr_i;
        end
    end

    // -----------------------------------------------------------------------
    // Response routing
    // -----------------------------------------------------------------------
    assign if_rvalid_o = resp_cyc && (owner_q == OWN_IF);
    assign ls_rvalid_o = resp_cyc && (owner_q == OWN_LS);
    assign if_rdata_o  = if_rvalid_o ? mem_rdata_i : '0;
    assign ls_rdata_o  = ls_rvalid_o ? mem_rdata_i : '0;

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        owner_d = owner_q;
        if (grant_opp) begin
            if (if_win || ls_win) begin
                state_d = S_BUSY;
                cnt_d   = CNT_LOAD;
                owner_d = if_win ? OWN_IF : OWN_LS;
            end else begin
                state_d = S_IDLE;
                cnt_d   = '0;
                owner_d = OWN_NONE;
            end
        end else if (state_q == S_BUSY) begin
            cnt_d = cnt_q - CNT_ONE;
        end
    end

    // A loss only counts when IF actually competed at a grant opportunity;
    // waiting while the memory is busy is not a loss.
    always_comb begin
        starve_d = starve_q;
        if (!if_req_i || if_win) begin
            starve_d = '0;
        end else if (ls_win && !starve_full) begin
            starve_d = starve_q + ST_ONE;
        end
    end

    // -----------------------------------------------------------------------
    // Registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            owner_q  <= OWN_NONE;
            starve_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            owner_q  <= owner_d;
            starve_q <= starve_d;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_port_arbiter
//
// Directed bench for mem_port_arbiter. Instance A uses MEM_LAT=1 and
// instance B uses MEM_LAT=3; both use STARVE_MAX=4. Inputs change 1 time
// unit after the rising edge. Outputs are checked 1 time unit later.
// ---------------------------------------------------------------------------
module tb_mem_port_arbiter;

  logic        clk;
  logic        rst_n;

  // Instance A (MEM_LAT=1)
  logic        a_if_req,  a_if_gnt,  a_if_rvalid;
  logic [31:0] a_if_addr, a_if_rdata;
  logic        a_ls_req,  a_ls_we,   a_ls_gnt, a_ls_rvalid;
  logic [3:0]  a_ls_be;
  logic [31:0] a_ls_addr, a_ls_wdata, a_ls_rdata;
  logic        a_mem_req, a_mem_we;
  logic [3:0]  a_mem_be;
  logic [31:0] a_mem_addr, a_mem_wdata, a_mem_rdata;

  // Instance B (MEM_LAT=3)
  logic        b_if_req,  b_if_gnt,  b_if_rvalid;
  logic [31:0] b_if_addr, b_if_rdata;
  logic        b_ls_req,  b_ls_we,   b_ls_gnt, b_ls_rvalid;
  logic [3:0]  b_ls_be;
  logic [31:0] b_ls_addr, b_ls_wdata, b_ls_rdata;
  logic        b_mem_req, b_mem_we;
  logic [3:0]  b_mem_be;
  logic [31:0] b_mem_addr, b_mem_wdata, b_mem_rdata;

  int n_assert = 0;
  int n_fail   = 0;

  // LS-wins pattern for six grants with both requests held (bit i = grant i)
  logic [5:0] ls_pat;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    if (obs !== exp) begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  mem_port_arbiter #(
    .ADDR_W(32), .DATA_W(32), .MEM_LAT(1), .STARVE_MAX(4)
  ) u_a (
    .clk(clk), .rst_n(rst_n),
    .if_req_i(a_if_req), .if_addr_i(a_if_addr), .if_gnt_o(a_if_gnt),
    .if_rvalid_o(a_if_rvalid), .if_rdata_o(a_if_rdata),
    .ls_req_i(a_ls_req), .ls_we_i(a_ls_we), .ls_be_i(a_ls_be),
    .ls_addr_i(a_ls_addr), .ls_wdata_i(a_ls_wdata), .ls_gnt_o(a_ls_gnt),
    .ls_rvalid_o(a_ls_rvalid), .ls_rdata_o(a_ls_rdata),
    .mem_req_o(a_mem_req), .mem_we_o(a_mem_we), .mem_be_o(a_mem_be),
    .mem_addr_o(a_mem_addr), .mem_wdata_o(a_mem_wdata), .mem_rdata_i(a_mem_rdata)
  );

  mem_port_arbiter #(
    .ADDR_W(32), .DATA_W(32), .MEM_LAT(3), .STARVE_MAX(4)
  ) u_b (
    .clk(clk), .rst_n(rst_n),
    .if_req_i(b_if_req), .if_addr_i(b_if_addr), .if_gnt_o(b_if_gnt),
    .if_rvalid_o(b_if_rvalid), .if_rdata_o(b_if_rdata),
    .ls_req_i(b_ls_req), .ls_we_i(b_ls_we), .ls_be_i(b_ls_be),
    .ls_addr_i(b_ls_addr), .ls_wdata_i(b_ls_wdata), .ls_gnt_o(b_ls_gnt),
    .ls_rvalid_o(b_ls_rvalid), .ls_rdata_o(b_ls_rdata),
    .mem_req_o(b_mem_req), .mem_we_o(b_mem_we), .mem_be_o(b_mem_be),
    .mem_addr_o(b_mem_addr), .mem_wdata_o(b_mem_wdata), .mem_rdata_i(b_mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    ls_pat = 6'b101111;

    // Reset asserted with every request high
    rst_n      = 1'b0;
    a_if_req   = 1'b1;  a_if_addr  = 32'h0000_0080;
    a_ls_req   = 1'b1;  a_ls_we    = 1'b0;  a_ls_be = 4'hF;
    a_ls_addr  = 32'h0000_0040;  a_ls_wdata = 32'h0;
    a_mem_rdata = 32'h0;
    b_if_req   = 1'b1;  b_if_addr  = 32'h0000_0300;
    b_ls_req   = 1'b1;  b_ls_we    = 1'b0;  b_ls_be = 4'hF;
    b_ls_addr  = 32'h0000_0500;  b_ls_wdata = 32'h0;
    b_mem_rdata = 32'hCAFE_0003;

    #2;
    chk("rst_a_ls_gnt",   a_ls_gnt,    1'b0);
    chk("rst_a_if_gnt",   a_if_gnt,    1'b0);
    chk("rst_a_mem_req",  a_mem_req,   1'b0);
    chk("rst_a_mem_addr", a_mem_addr,  32'h0);
    chk("rst_b_mem_req",  b_mem_req,   1'b0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_a_ls_rvalid", a_ls_rvalid, 1'b0);
    chk("rst_a_if_rvalid", a_if_rvalid, 1'b0);
    chk("rst_a_if_rdata",  a_if_rdata,  32'h0);
    chk("rst_b_ls_gnt",    b_ls_gnt,    1'b0);

    // Release: LS wins the first cycle on A
    b_if_req = 1'b0;  b_ls_req = 1'b0;
    rst_n = 1'b1;
    #1;
    chk("rel_a_ls_gnt",   a_ls_gnt,   1'b1);
    chk("rel_a_if_gnt",   a_if_gnt,   1'b0);
    chk("rel_a_mem_req",  a_mem_req,  1'b1);
    chk("rel_a_mem_addr", a_mem_addr, 32'h0000_0040);
    chk("rel_a_mem_we",   a_mem_we,   1'b0);
    chk("rel_b_mem_req",  b_mem_req,  1'b0);

    // T+1: LS response, IF granted back-to-back
    @(posedge clk); #1;
    a_ls_req = 1'b0;  a_mem_rdata = 32'h1111_2222;
    #1;
    chk("bb_a_ls_rvalid", a_ls_rvalid, 1'b1);
    chk("bb_a_ls_rdata",  a_ls_rdata,  32'h1111_2222);
    chk("bb_a_if_gnt",    a_if_gnt,    1'b1);
    chk("bb_a_if_rdata",  a_if_rdata,  32'h0);
    chk("bb_a_mem_addr",  a_mem_addr,  32'h0000_0080);
    chk("bb_a_mem_be",    a_mem_be,    4'hF);

    // T+2: IF response
    @(posedge clk); #1;
    a_if_req = 1'b0;  a_mem_rdata = 32'h3333_4444;
    #1;
    chk("bb_a_if_rvalid",  a_if_rvalid, 1'b1);
    chk("bb_a_if_rdata2",  a_if_rdata,  32'h3333_4444);
    chk("bb_a_ls_rvalid2", a_ls_rvalid, 1'b0);
    chk("bb_a_mem_req2",   a_mem_req,   1'b0);
    @(posedge clk); #1;
    chk("bb_a_if_rvalid3", a_if_rvalid, 1'b0);

    // IF-only fetch at 0x100
    a_if_req = 1'b1;  a_if_addr = 32'h0000_0100;
    #1;
    chk("if_a_gnt",      a_if_gnt,    1'b1);
    chk("if_a_mem_addr", a_mem_addr,  32'h0000_0100);
    chk("if_a_mem_wd",   a_mem_wdata, 32'h0);
    chk("if_a_mem_we",   a_mem_we,    1'b0);
    @(posedge clk); #1;
    a_if_req = 1'b0;  a_mem_rdata = 32'h0000_0013;
    #1;
    chk("if_a_rvalid", a_if_rvalid, 1'b1);
    chk("if_a_rdata",  a_if_rdata,  32'h0000_0013);
    @(posedge clk); #1;
    chk("if_a_rvalid_off", a_if_rvalid, 1'b0);

    // Store on A
    a_ls_req = 1'b1;  a_ls_we = 1'b1;  a_ls_be = 4'b0011;
    a_ls_addr = 32'h0000_2000;  a_ls_wdata = 32'hDEAD_BEEF;
    #1;
    chk("st_a_gnt",      a_ls_gnt,    1'b1);
    chk("st_a_mem_we",   a_mem_we,    1'b1);
    chk("st_a_mem_be",   a_mem_be,    4'b0011);
    chk("st_a_mem_wd",   a_mem_wdata, 32'hDEAD_BEEF);
    @(posedge clk); #1;
    a_ls_req = 1'b0;  a_ls_we = 1'b0;  a_ls_be = 4'hF;
    #1;
    chk("st_a_rvalid", a_ls_rvalid, 1'b1);
    @(posedge clk); #1;

    // Starvation: both held high, LS x4, IF, LS
    a_if_req = 1'b1;  a_ls_req = 1'b1;
    a_ls_addr = 32'h0000_0040;  a_if_addr = 32'h0000_0080;
    for (int unsigned i = 0; i < 6; i++) begin
      #1;
      chk("sv_a_ls_gnt", a_ls_gnt, ls_pat[i]);
      chk("sv_a_if_gnt", a_if_gnt, !ls_pat[i]);
      if (i > 0) begin
        chk("sv_a_ls_rvalid", a_ls_rvalid, ls_pat[i-1]);
        chk("sv_a_if_rvalid", a_if_rvalid, !ls_pat[i-1]);
      end
      @(posedge clk); #1;
    end
    a_if_req = 1'b0;  a_ls_req = 1'b0;
    #1;
    chk("sv_a_ls_rvalid_last", a_ls_rvalid, 1'b1);
    chk("sv_a_mem_req_last",   a_mem_req,   1'b0);
    @(posedge clk); #1;

    // Store on B (MEM_LAT=3), IF waits while busy
    b_ls_req = 1'b1;  b_ls_we = 1'b1;  b_ls_be = 4'b0011;
    b_ls_addr = 32'h0000_2000;  b_ls_wdata = 32'hDEAD_BEEF;
    #1;
    chk("st_b_gnt",      b_ls_gnt,    1'b1);
    chk("st_b_mem_we",   b_mem_we,    1'b1);
    chk("st_b_mem_be",   b_mem_be,    4'b0011);
    chk("st_b_mem_addr", b_mem_addr,  32'h0000_2000);
    chk("st_b_mem_wd",   b_mem_wdata, 32'hDEAD_BEEF);
    @(posedge clk); #1;
    b_ls_req = 1'b0;  b_ls_we = 1'b0;  b_ls_be = 4'hF;
    b_if_req = 1'b1;
    for (int unsigned k = 0; k < 2; k++) begin
      #1;
      chk("st_b_wait_if_gnt", b_if_gnt,    1'b0);
      chk("st_b_wait_memreq", b_mem_req,   1'b0);
      chk("st_b_wait_rvalid", b_ls_rvalid, 1'b0);
      @(posedge clk); #1;
    end
    #1;
    chk("st_b_rvalid",   b_ls_rvalid, 1'b1);
    chk("st_b_if_gnt",   b_if_gnt,    1'b1);
    chk("st_b_if_addr",  b_mem_addr,  32'h0000_0300);
    @(posedge clk); #1;
    b_if_req = 1'b0;
    #1;
    chk("if_b_rvalid_t1", b_if_rvalid, 1'b0);
    chk("if_b_memreq_t1", b_mem_req,   1'b0);
    @(posedge clk); #1;
    chk("if_b_rvalid_t2", b_if_rvalid, 1'b0);
    @(posedge clk); #1;
    chk("if_b_rvalid_t3", b_if_rvalid, 1'b1);
    chk("if_b_rdata",     b_if_rdata,  32'hCAFE_0003);
    chk("if_b_ls_rdata",  b_ls_rdata,  32'h0);
    @(posedge clk); #1;

    // Reset in the middle of a B access: no response afterwards
    b_ls_req = 1'b1;  b_ls_addr = 32'h0000_0500;
    #1;
    chk("mr_b_gnt", b_ls_gnt, 1'b1);
    @(posedge clk); #1;
    b_ls_req = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("mr_b_rvalid_rst", b_ls_rvalid, 1'b0);
    chk("mr_b_memreq_rst", b_mem_req,   1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int unsigned k = 0; k < 5; k++) begin
      #1;
      chk("mr_b_ls_rvalid", b_ls_rvalid, 1'b0);
      chk("mr_b_if_rvalid", b_if_rvalid, 1'b0);
      @(posedge clk); #1;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
